// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor: BTB entry layout, PHT counter encoding
// and the saturating counter update rule.
package BranchPredictorTypes;

  // Largest tag that can occur, reached at the smallest BTB (4 entries, 2 index bits).
  localparam int TAG_MAX_W = 28;

  typedef logic [1:0]  PhtCounter;
  typedef logic [11:0] PhtIndex;
  typedef logic [9:0]  BtbIndex;

  localparam PhtCounter PHT_RESET           = 2'd1;
  localparam PhtCounter PHT_TAKEN_THRESHOLD = 2'd2;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } BtbEntry;

  function automatic PhtCounter pht_next(input PhtCounter ctr, input logic taken);
    PhtCounter nxt;
    nxt = ctr;
    if (taken && ctr != 2'd3) nxt = ctr + 2'd1;
    else if (!taken && ctr != 2'd0) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_predictor_pht.sv
// Gshare counter array: zero-latency combinational read, negedge saturating update.
// No backpressure: at most one write per cycle, always accepted.
module pattern_history_table
  import BranchPredictorTypes::*;
#(
  parameter  int ENTRIES = 256,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  output PhtCounter     rd_ctr,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);

  PhtCounter ctr [ENTRIES];

  assign rd_ctr = ctr[rd_idx];

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= PHT_RESET;
    end else if (wr_en) begin
      ctr[wr_idx] <= pht_next(ctr[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB plus gshare PHT; lookup is combinational (zero latency), training on negedge.
// No backpressure: resolution updates are fire-and-forget, one per cycle.
module branch_target_predictor
  import BranchPredictorTypes::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int HIST_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [31:0]                    fetchPc,
  output logic                           isBranchTakenPredicted,
  output logic                           btbHit,
  output logic [31:0]                    btbPredictedPc,
  output logic [$clog2(PHT_ENTRIES)-1:0] predictPhtIdx,
  input  logic                           updateEn,
  input  logic [31:0]                    updatePc,
  input  logic                           updateTaken,
  input  logic [31:0]                    updateTarget,
  input  logic [$clog2(PHT_ENTRIES)-1:0] updatePhtIdx
);

  localparam int BIW = $clog2(BTB_ENTRIES);
  localparam int PIW = $clog2(PHT_ENTRIES);

  logic [HIST_BITS-1:0] ghr;
  BtbEntry              btb [BTB_ENTRIES];
  BtbEntry              rd_entry;
  logic [BIW-1:0]       rd_slot;
  logic [BIW-1:0]       wr_slot;
  logic [TAG_MAX_W-1:0] rd_tag;
  logic [TAG_MAX_W-1:0] wr_tag;
  PhtCounter            rd_ctr;
  logic                 unused_pc_bits;

  // Byte offset within the instruction word never participates in prediction.
  assign unused_pc_bits = ^{fetchPc[1:0], updatePc[1:0]};

  assign rd_slot  = fetchPc[2 +: BIW];
  assign wr_slot  = updatePc[2 +: BIW];
  assign rd_tag   = TAG_MAX_W'(fetchPc[31:2+BIW]);
  assign wr_tag   = TAG_MAX_W'(updatePc[31:2+BIW]);
  assign rd_entry = btb[rd_slot];

  assign btbHit                 = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign btbPredictedPc         = btbHit ? rd_entry.target : 32'd0;
  assign predictPhtIdx          = fetchPc[2 +: PIW] ^ PIW'(ghr);
  assign isBranchTakenPredicted = (rd_ctr >= PHT_TAKEN_THRESHOLD);

  pattern_history_table #(
    .ENTRIES (PHT_ENTRIES)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (predictPhtIdx),
    .rd_ctr   (rd_ctr),
    .wr_en    (updateEn),
    .wr_idx   (updatePhtIdx),
    .wr_taken (updateTaken)
  );

  // Not-taken resolutions leave the BTB alone; taken ones overwrite whatever aliases there.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
    end else if (updateEn) begin
      ghr <= HIST_BITS'({ghr, updateTaken});
      if (updateTaken) begin
        btb[wr_slot] <= '{valid: 1'b1, tag: wr_tag, target: updateTarget};
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomised and directed bench for branch_target_predictor against a behavioural model.
module tb_branch_target_predictor;

  localparam int BTB_N = 64;
  localparam int PHT_N = 256;
  localparam int HB    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetchPc;
  logic        isBranchTakenPredicted;
  logic        btbHit;
  logic [31:0] btbPredictedPc;
  logic [7:0]  predictPhtIdx;
  logic        updateEn;
  logic [31:0] updatePc;
  logic        updateTaken;
  logic [31:0] updateTarget;
  logic [7:0]  updatePhtIdx;

  branch_target_predictor #(
    .BTB_ENTRIES (BTB_N),
    .PHT_ENTRIES (PHT_N),
    .HIST_BITS   (HB)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .fetchPc                (fetchPc),
    .isBranchTakenPredicted (isBranchTakenPredicted),
    .btbHit                 (btbHit),
    .btbPredictedPc         (btbPredictedPc),
    .predictPhtIdx          (predictPhtIdx),
    .updateEn               (updateEn),
    .updatePc               (updatePc),
    .updateTaken            (updateTaken),
    .updateTarget           (updateTarget),
    .updatePhtIdx           (updatePhtIdx)
  );

  always #5 clk = ~clk;

  // Reference model: word-address keyed BTB, plain integer counters and history.
  bit          m_valid  [BTB_N];
  int unsigned m_word   [BTB_N];
  logic [31:0] m_target [BTB_N];
  int          m_pht    [PHT_N];
  int unsigned m_ghr;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < BTB_N; i++) begin
      m_valid[i]  = 1'b0;
      m_word[i]   = 0;
      m_target[i] = 32'd0;
    end
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
    m_ghr = 0;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input bit tk,
                                       input logic [31:0] tgt, input int idx);
    int slot;
    if (tk) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
    else    m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
    if (tk) begin
      slot           = int'((pc >> 2) % BTB_N);
      m_valid[slot]  = 1'b1;
      m_word[slot]   = pc >> 2;
      m_target[slot] = tgt;
    end
    m_ghr = ((m_ghr << 1) | (tk ? 1 : 0)) % (1 << HB);
  endfunction

  task automatic check_lookup(input string tag);
    int          slot;
    int unsigned idx;
    bit          hit;
    slot = int'((fetchPc >> 2) % BTB_N);
    hit  = m_valid[slot] && (m_word[slot] == (fetchPc >> 2));
    idx  = ((fetchPc >> 2) % PHT_N) ^ m_ghr;
    check_eq({tag, ".hit"},   32'(btbHit), 32'(hit));
    check_eq({tag, ".tgt"},   btbPredictedPc, hit ? m_target[slot] : 32'd0);
    check_eq({tag, ".idx"},   32'(predictPhtIdx), idx);
    check_eq({tag, ".taken"}, 32'(isBranchTakenPredicted), (m_pht[idx] >= 2) ? 32'd1 : 32'd0);
  endtask

  // Retire the update held over the last negedge into the model, then drive and check.
  task automatic commit();
    @(negedge clk);
    #1;
    if (updateEn && rst) model_update(updatePc, updateTaken, updateTarget, int'(updatePhtIdx));
  endtask

  task automatic step(input logic [31:0] pc, input bit en, input logic [31:0] upc,
                      input bit tk, input logic [31:0] tgt, input logic [7:0] idx,
                      input string tag);
    commit();
    @(posedge clk);
    fetchPc      = pc;
    updateEn     = en;
    updatePc     = upc;
    updateTaken  = tk;
    updateTarget = tgt;
    updatePhtIdx = idx;
    #1;
    check_lookup(tag);
  endtask

  task automatic lookup_idx(input int target_idx, input string tag);
    logic [31:0] pc;
    commit();
    pc = 32'((target_idx ^ m_ghr) % PHT_N) << 2;
    @(posedge clk);
    fetchPc  = pc;
    updateEn = 1'b0;
    #1;
    check_lookup(tag);
    check_eq({tag, ".mapped"}, 32'(predictPhtIdx), 32'(target_idx));
  endtask

  initial begin
    rst          = 1'b0;
    fetchPc      = 32'h100;
    updateEn     = 1'b0;
    updatePc     = 32'd0;
    updateTaken  = 1'b0;
    updateTarget = 32'd0;
    updatePhtIdx = 8'd0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_lookup("reset");
    check_eq("reset.idx40", 32'(predictPhtIdx), 32'h40);
    check_eq("reset.hit0",  32'(btbHit), 32'd0);
    #1 rst = 1'b1;

    // First training: ghr becomes 1, so 0x100 now indexes counter 0x41.
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 8'h40, "train0");
    step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, "look0");
    check_eq("look0.hit",   32'(btbHit), 32'd1);
    check_eq("look0.tgt",   btbPredictedPc, 32'h200);
    check_eq("look0.idx41", 32'(predictPhtIdx), 32'h41);
    check_eq("look0.nt",    32'(isBranchTakenPredicted), 32'd0);

    // Saturation of counter 0x10.
    for (int i = 0; i < 4; i++) step(32'h0, 1'b1, 32'h1040, 1'b1, 32'h2000, 8'h10, "sat_up");
    lookup_idx(32'h10, "sat3");
    check_eq("sat3.taken", 32'(isBranchTakenPredicted), 32'd1);
    step(32'h0, 1'b1, 32'h1040, 1'b0, 32'h0, 8'h10, "sat_dn1");
    lookup_idx(32'h10, "sat2");
    check_eq("sat2.taken", 32'(isBranchTakenPredicted), 32'd1);
    step(32'h0, 1'b1, 32'h1040, 1'b0, 32'h0, 8'h10, "sat_dn2");
    lookup_idx(32'h10, "sat1");
    check_eq("sat1.nt", 32'(isBranchTakenPredicted), 32'd0);

    // BTB aliasing: 0x100 and 0x200 share slot 0.
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 8'h05, "alias_a");
    step(32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 8'h06, "alias_b");
    step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, "alias_old");
    check_eq("alias_old.miss", 32'(btbHit), 32'd0);
    step(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, "alias_new");
    check_eq("alias_new.hit", 32'(btbHit), 32'd1);
    check_eq("alias_new.tgt", btbPredictedPc, 32'h300);

    // Read-during-write returns old contents.
    step(32'h400, 1'b1, 32'h400, 1'b1, 32'h440, 8'h07, "rdw");
    check_eq("rdw.same", 32'(btbHit), 32'd0);
    step(32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, "rdw_next");
    check_eq("rdw.next_hit", 32'(btbHit), 32'd1);
    check_eq("rdw.next_tgt", btbPredictedPc, 32'h440);

    for (int i = 0; i < 400; i++) begin
      step(32'($urandom_range(0, 511) << 2) | 32'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)),
           32'($urandom_range(0, 511) << 2) | 32'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)),
           $urandom,
           8'($urandom_range(0, 255)),
           "rnd");
    end

    // Mid-stream reset with a coincident update that must be discarded.
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'hABC, 8'h40, "pre_rst");
    #1 rst = 1'b0;
    model_reset();
    #1;
    check_lookup("in_rst");
    check_eq("in_rst.hit",   32'(btbHit), 32'd0);
    check_eq("in_rst.tgt",   btbPredictedPc, 32'd0);
    check_eq("in_rst.taken", 32'(isBranchTakenPredicted), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    updateEn = 1'b0;
    rst      = 1'b1;
    step(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, "post_rst_a");
    check_eq("post_rst_a.miss", 32'(btbHit), 32'd0);
    check_eq("post_rst_a.idx",  32'(predictPhtIdx), 32'h40);
    step(32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0, "post_rst_b");
    check_eq("post_rst_b.miss", 32'(btbHit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
